// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Constants and helpers shared by the RV32I execute-stage blocks.
//   - ALU_* : 5-bit operation select codes driven on rv_alu_unit.i_ctrl.
//   - ALU_SRC_OP1_* / ALU_SRC_OP2_* : operand-source mux selects used by the
//     execute stage ahead of the ALU (rs1 vs PC, rs2 vs immediate).
//   - STAGED_BP_* : forwarding (bypass) source codes for operand hazards.
//   - cmp_t / alu_compare() : one shared comparator feeding SLT/SLTU and all
//     branch-compare operations.
//   - bit_reverse() : lets the single right-shifter also perform SLL.
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN = 32;

  // ALU operation select codes.
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_EQ     = 5'd10;
  localparam logic [4:0] ALU_NE     = 5'd11;
  localparam logic [4:0] ALU_LT     = 5'd12;
  localparam logic [4:0] ALU_GE     = 5'd13;
  localparam logic [4:0] ALU_LTU    = 5'd14;
  localparam logic [4:0] ALU_GEU    = 5'd15;
  localparam logic [4:0] ALU_PASS_B = 5'd16;
  localparam logic [4:0] ALU_PASS_A = 5'd17;

  // Operand A source: register file or program counter (AUIPC, JAL).
  localparam logic ALU_SRC_OP1_RS1 = 1'b0;
  localparam logic ALU_SRC_OP1_PC  = 1'b1;

  // Operand B source: register file or decoded immediate.
  localparam logic ALU_SRC_OP2_RS2 = 1'b0;
  localparam logic ALU_SRC_OP2_IMM = 1'b1;

  // Forwarding source for an operand that has a pending write.
  localparam logic [1:0] STAGED_BP_NONE = 2'd0;  // register file value
  localparam logic [1:0] STAGED_BP_EX   = 2'd1;  // from EX/MEM result
  localparam logic [1:0] STAGED_BP_MEM  = 2'd2;  // from MEM/WB result
  localparam logic [1:0] STAGED_BP_WB   = 2'd3;  // from write-back port

  // Comparator outputs shared by SLT/SLTU and the branch compares.
  typedef struct packed {
    logic eq;   // a == b
    logic lt;   // signed a < signed b
    logic ltu;  // unsigned a < unsigned b
  } cmp_t;

  function automatic cmp_t alu_compare(input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    cmp_t c;
    c.eq  = (a == b);
    c.lt  = ($signed(a) < $signed(b));
    c.ltu = (a < b);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_alu_unit.sv
// ---------------------------------------------------------------------------
// rv_alu_unit
// RV32I integer ALU for the execute stage. The result and zero flag are
// purely combinational (result bit 0 doubles as branch-taken in the same
// cycle); a registered copy of both is provided for timing-relaxed consumers.
//
// Ports:
//   i_clk       in   1  clock, rising edge
//   i_reset_n   in   1  asynchronous active-low reset (registered copy only)
//   i_src_a     in  32  operand A (rs1 or PC)
//   i_src_b     in  32  operand B (rs2 or immediate); B[4:0] is the shamt
//   i_ctrl      in   5  operation select (rv_pkg::ALU_*); 18..31 give 0
//   o_result    out 32  combinational result
//   o_zero      out  1  combinational, o_result == 0
//   o_result_q  out 32  o_result registered on rising i_clk
//   o_zero_q    out  1  o_zero registered on rising i_clk
//
// WIDTH is fixed at 32: the shift amount width and the comparator/reverse
// helpers in rv_pkg assume XLEN = 32.
// ---------------------------------------------------------------------------
module rv_alu_unit
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic [4:0]       i_ctrl,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic [WIDTH-1:0] o_result_q,
  output logic             o_zero_q
);

  // -------------------------------------------------------------------------
  // Adder / subtractor. SUB is A + ~B + 1 so a single carry chain serves
  // both; wraparound is intentional and no carry or overflow is exported.
  // -------------------------------------------------------------------------
  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;

  assign is_sub = (i_ctrl == ALU_SUB);
  assign add_b  = is_sub ? ~i_src_b : i_src_b;
  assign sum    = i_src_a + add_b + {{(WIDTH-1){1'b0}}, is_sub};

  // -------------------------------------------------------------------------
  // Single barrel shifter. It only shifts right; SLL reverses the operand on
  // the way in and the result on the way out. The extra top bit carries the
  // fill value so one arithmetic shift covers SRL (fill 0) and SRA (fill
  // A[31]). Only B[4:0] is used, so a shift of 32 behaves as a shift of 0.
  // -------------------------------------------------------------------------
  logic [4:0]       shamt;
  logic             is_sll;
  logic             shift_fill;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH:0]   shift_ext;
  logic [WIDTH-1:0] shift_right;
  logic [WIDTH-1:0] shift_left;

  assign shamt       = i_src_b[4:0];
  assign is_sll      = (i_ctrl == ALU_SLL);
  assign shift_fill  = (i_ctrl == ALU_SRA) & i_src_a[WIDTH-1];
  assign shift_in    = is_sll ? bit_reverse(i_src_a) : i_src_a;
  assign shift_ext   = $signed({shift_fill, shift_in}) >>> shamt;
  assign shift_right = shift_ext[WIDTH-1:0];
  assign shift_left  = bit_reverse(shift_right);

  // -------------------------------------------------------------------------
  // Shared comparator for SLT/SLTU and the six branch conditions.
  // -------------------------------------------------------------------------
  cmp_t cmp;

  assign cmp = alu_compare(i_src_a, i_src_b);

  // -------------------------------------------------------------------------
  // Result select. Flag-style operations only ever drive bit 0.
  // -------------------------------------------------------------------------
  logic             flag;
  logic             flag_op;
  logic [WIDTH-1:0] result;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that keeps the block free of inferred latches and makes
    // the reserved codes produce a defined zero.
    flag    = 1'b0;
    flag_op = 1'b0;
    result  = '0;
    unique case (i_ctrl)
      ALU_ADD,
      ALU_SUB:    result = sum;
      ALU_SLL:    result = shift_left;
      ALU_SRL,
      ALU_SRA:    result = shift_right;
      ALU_XOR:    result = i_src_a ^ i_src_b;
      ALU_OR:     result = i_src_a | i_src_b;
      ALU_AND:    result = i_src_a & i_src_b;
      ALU_PASS_B: result = i_src_b;
      ALU_PASS_A: result = i_src_a;
      ALU_SLT,
      ALU_LT:     begin flag_op = 1'b1; flag = cmp.lt;   end
      ALU_SLTU,
      ALU_LTU:    begin flag_op = 1'b1; flag = cmp.ltu;  end
      ALU_EQ:     begin flag_op = 1'b1; flag = cmp.eq;   end
      ALU_NE:     begin flag_op = 1'b1; flag = ~cmp.eq;  end
      ALU_GE:     begin flag_op = 1'b1; flag = ~cmp.lt;  end
      ALU_GEU:    begin flag_op = 1'b1; flag = ~cmp.ltu; end
      default:    result = '0;
    endcase
    if (flag_op) begin
      result = {{(WIDTH-1){1'b0}}, flag};
    end
  end

  assign o_result = result;
  assign o_zero   = (result == '0);

  // -------------------------------------------------------------------------
  // Registered copy: one-cycle latency, no enable. Reset clears it at once,
  // independent of the clock, and the first edge after release captures the
  // live combinational value.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d,   zero_q;

  assign result_d = result;
  assign zero_d   = o_zero;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value, independent of statement order or other processes.
    if (!i_reset_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign o_result_q = result_q;
  assign o_zero_q   = zero_q;

endmodule

// File: tb/tb_rv_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_rv_alu_unit
// Self-checking bench for rv_alu_unit: directed vector table, a randomized
// run against a behavioural model, and the registered-path / async-reset
// sequence.
// ---------------------------------------------------------------------------
module tb_rv_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  ctrl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] result_q;
  logic        zero_q;

  int n_tests = 0;
  int n_fail  = 0;

  rv_alu_unit #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_src_a    (src_a),
    .i_src_b    (src_b),
    .i_ctrl     (ctrl),
    .o_result   (result),
    .o_zero     (zero),
    .o_result_q (result_q),
    .o_zero_q   (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ctrl;
    logic [31:0] exp_r;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] c, input logic [31:0] r,
                         input logic z);
    vec_t v;
    v.a = a; v.b = b; v.ctrl = c; v.exp_r = r; v.exp_z = z;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference written straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int op);
    int          sh;
    longint      sa, sb;
    longint      ua, ub;
    logic [31:0] r;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = 32'h0;
    case (op)
      0:  r = 32'((ua + ub) % 64'h1_0000_0000);
      1:  r = 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
      2:  r = 32'(ua * (64'd1 << sh));
      3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4:  r = (ua < ub) ? 32'd1 : 32'd0;
      5:  r = a ^ b;
      6:  r = 32'(ua / (64'd1 << sh));
      7:  begin
            // floor division by 2^sh gives sign-filled right shift
            longint q;
            q = sa / (64'sd1 <<< sh);
            if ((sa < 0) && (q * (64'sd1 <<< sh) != sa)) q = q - 1;
            r = 32'(q);
          end
      8:  r = a | b;
      9:  r = a & b;
      10: r = (a == b) ? 32'd1 : 32'd0;
      11: r = (a != b) ? 32'd1 : 32'd0;
      12: r = (sa <  sb) ? 32'd1 : 32'd0;
      13: r = (sa >= sb) ? 32'd1 : 32'd0;
      14: r = (ua <  ub) ? 32'd1 : 32'd0;
      15: r = (ua >= ub) ? 32'd1 : 32'd0;
      16: r = b;
      17: r = a;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] exp_r;
    logic [31:0] a_r, b_r;
    int          op_r;

    // Directed vectors.
    add_vec(32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1);
    add_vec(32'h0, 32'h1, 5'd1, 32'hFFFF_FFFF, 1'b0);
    add_vec(32'h8000_0000, 32'h24, 5'd6, 32'h0800_0000, 1'b0);
    add_vec(32'h8000_0000, 32'h24, 5'd7, 32'hF800_0000, 1'b0);
    add_vec(32'h1, 32'h24, 5'd2, 32'h10, 1'b0);
    add_vec(32'hDEAD_BEEF, 32'h20, 5'd2, 32'hDEAD_BEEF, 1'b0);
    add_vec(32'h8000_0000, 32'h1F, 5'd7, 32'hFFFF_FFFF, 1'b0);
    add_vec(32'h8000_0000, 32'h1F, 5'd6, 32'h1, 1'b0);
    add_vec(32'hFFFF_FFFF, 32'h1, 5'd3, 32'h1, 1'b0);
    add_vec(32'hFFFF_FFFF, 32'h1, 5'd4, 32'h0, 1'b1);
    add_vec(32'hFFFF_FFFF, 32'h1, 5'd12, 32'h1, 1'b0);
    add_vec(32'hFFFF_FFFF, 32'h1, 5'd15, 32'h1, 1'b0);
    add_vec(32'hFFFF_FFFF, 32'h1, 5'd13, 32'h0, 1'b1);
    add_vec(32'hFFFF_FFFF, 32'h1, 5'd14, 32'h0, 1'b1);
    add_vec(32'h1234_5678, 32'h1234_5678, 5'd10, 32'h1, 1'b0);
    add_vec(32'h1234_5678, 32'h1234_5678, 5'd11, 32'h0, 1'b1);
    add_vec(32'h1234_5678, 32'h1234_5678, 5'd13, 32'h1, 1'b0);
    add_vec(32'h1234_5678, 32'h1234_5678, 5'd15, 32'h1, 1'b0);
    add_vec(32'h1234_5678, 32'h1234_5678, 5'd12, 32'h0, 1'b1);
    add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, 32'hFF00_FF00, 1'b0);
    add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd8, 32'hFFF0_FFF0, 1'b0);
    add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd9, 32'h00F0_00F0, 1'b0);
    add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd16, 32'h0FF0_0FF0, 1'b0);
    add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd17, 32'hF0F0_F0F0, 1'b0);
    add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd31, 32'h0, 1'b1);
    add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'h0, 1'b1);

    // Reset state: registered outputs cleared before any clock edge.
    rst_n = 1'b0;
    src_a = 32'd3;
    src_b = 32'd4;
    ctrl  = 5'd0;
    #1;
    check("reset_result_q", result_q, 32'h0);
    check("reset_zero_q", {31'b0, zero_q}, 32'h0);
    check("comb_during_reset", result, 32'd7);
    @(posedge clk); #1;
    check("reset_hold_result_q", result_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, combinational path.
    foreach (vecs[i]) begin
      @(negedge clk);
      src_a = vecs[i].a;
      src_b = vecs[i].b;
      ctrl  = vecs[i].ctrl;
      #1;
      check($sformatf("vec%0d_result(ctrl=%0d)", i, vecs[i].ctrl),
            result, vecs[i].exp_r);
      check($sformatf("vec%0d_zero(ctrl=%0d)", i, vecs[i].ctrl),
            {31'b0, zero}, {31'b0, vecs[i].exp_z});
    end

    // Randomized: combinational and registered path against the model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      op_r = int'($urandom_range(0, 31));
      a_r  = $urandom;
      case ($urandom_range(0, 3))
        0:       b_r = a_r;
        1:       b_r = $urandom_range(0, 40);
        default: b_r = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a_r = {a_r[31], 31'h0};
      src_a = a_r;
      src_b = b_r;
      ctrl  = 5'(op_r);
      exp_r = ref_alu(a_r, b_r, op_r);
      #1;
      check($sformatf("rand%0d_result(op=%0d a=%h b=%h)", n, op_r, a_r, b_r),
            result, exp_r);
      check($sformatf("rand%0d_zero", n), {31'b0, zero},
            {31'b0, (exp_r == 32'h0)});
      @(posedge clk); #1;
      check($sformatf("rand%0d_result_q", n), result_q, exp_r);
      check($sformatf("rand%0d_zero_q", n), {31'b0, zero_q},
            {31'b0, (exp_r == 32'h0)});
    end

    // Registered path with asynchronous reset mid-stream.
    @(negedge clk);
    src_a = 32'd5;
    src_b = 32'd7;
    ctrl  = 5'd0;
    @(posedge clk); #1;
    check("seq_add_result_q", result_q, 32'd12);
    check("seq_add_zero_q", {31'b0, zero_q}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("seq_async_clear_result_q", result_q, 32'h0);
    check("seq_async_clear_zero_q", {31'b0, zero_q}, 32'h0);
    check("seq_comb_unaffected", result, 32'd12);
    @(posedge clk); #1;
    check("seq_reset_held_result_q", result_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("seq_release_no_edge", result_q, 32'h0);
    @(posedge clk); #1;
    check("seq_recapture_result_q", result_q, 32'd12);
    check("seq_recapture_zero_q", {31'b0, zero_q}, 32'h0);

    // Zero flag through the registered path.
    @(negedge clk);
    src_a = 32'h1;
    src_b = 32'h1;
    ctrl  = 5'd1;
    @(posedge clk); #1;
    check("seq_sub_zero_q", {31'b0, zero_q}, 32'h1);
    check("seq_sub_result_q", result_q, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
